// File: rtl/fifo_read_packer_if.sv
// fifo_read_packer_if: FIFO read port plus packed output stream of the read-side packer.
interface fifo_read_packer_if #(parameter int DSIZE = 8, parameter int RATIO = 2);
  logic                   rempty;
  logic [DSIZE-1:0]       rdata;
  logic                   rinc;
  logic                   m_valid;
  logic                   m_ready;
  logic [RATIO*DSIZE-1:0] m_data;
  logic [RATIO-1:0]       m_keep;
  logic                   m_last;
  modport master (input rempty, rdata, m_ready, output rinc, m_valid, m_data, m_keep, m_last);
  modport slave (output rempty, rdata, m_ready, input rinc, m_valid, m_data, m_keep, m_last);
endinterface

// File: rtl/fifo_read_packer.sv
// fifo_read_packer: pops FIFO words and packs RATIO of them per output beat, with flush for partial beats.
module fifo_read_packer #(
  parameter int DSIZE = 8,
  parameter int RATIO = 2,
  parameter int CNT_W = 16
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                flush,
  fifo_read_packer_if.master  bus,
  output logic [CNT_W-1:0]    beat_cnt,
  output logic                busy
);
  localparam int AW = $clog2(RATIO + 1);
  logic [RATIO-1:0][DSIZE-1:0] acc_q, acc_d;
  logic [AW-1:0]               cnt_q, cnt_d;
  logic                        pend_q, pend_d, valid_q, valid_d, last_q, last_d;
  logic [RATIO*DSIZE-1:0]      data_q, data_d;
  logic [RATIO-1:0]            keep_q, keep_d, fill;
  logic [CNT_W-1:0]            beat_q, beat_d;
  logic                        load, pop;
  always_comb begin
    load = (cnt_q == AW'(RATIO) || (pend_q && cnt_q != '0)) && (!valid_q || bus.m_ready);
    pop = rrst_n && !bus.rempty && !pend_q && (cnt_q < AW'(RATIO) || load);
    acc_d = acc_q;
    fill = '0;
    data_d = data_q;
    for (int i = 0; i < RATIO; i++) begin
      fill[i] = AW'(i) < cnt_q;
      if (pop && AW'(i) == (load ? AW'(0) : cnt_q)) acc_d[i] = bus.rdata;
      if (load) data_d[i*DSIZE +: DSIZE] = fill[i] ? acc_q[i] : '0;
    end
    cnt_d = load ? AW'(pop) : cnt_q + AW'(pop);
    keep_d = load ? fill : keep_q;
    last_d = load ? pend_q : last_q;
    valid_d = load || (valid_q && !bus.m_ready);
    // flush applies to what the accumulator holds after this edge, so it never pends on an empty acc
    pend_d = (pend_q && !load) || (flush && cnt_d != '0);
    beat_d = beat_q + CNT_W'(valid_q && bus.m_ready);
  end
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      beat_q  <= '0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      beat_q  <= beat_d;
    end
  end
  assign bus.rinc    = pop;
  assign bus.m_valid = valid_q;
  assign bus.m_data  = data_q;
  assign bus.m_keep  = keep_q;
  assign bus.m_last  = last_q;
  assign beat_cnt    = beat_q;
  assign busy        = cnt_q != '0 || valid_q || pend_q;
endmodule

// File: tb/tb_fifo_read_packer.sv
// tb_fifo_read_packer: directed checks of the packer against a queue-based FIFO model and beat monitor.
module tb_fifo_read_packer;
  localparam int DSIZE = 8;
  localparam int RATIO = 2;
  localparam int CNT_W = 16;
  typedef struct packed {logic [15:0] d; logic [1:0] k; logic l;} beat_t;
  logic             rclk = 1'b0;
  logic             rrst_n = 1'b0;
  logic             flush = 1'b0;
  logic [CNT_W-1:0] beat_cnt;
  logic             busy;
  int               n_cmp = 0;
  int               n_bad = 0;
  logic [7:0]       fifo[$];
  logic [7:0]       inq[$];
  beat_t            rcv[$];
  logic             p;
  fifo_read_packer_if #(.DSIZE(DSIZE), .RATIO(RATIO)) bus();
  fifo_read_packer #(.DSIZE(DSIZE), .RATIO(RATIO), .CNT_W(CNT_W)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .flush(flush), .bus(bus), .beat_cnt(beat_cnt), .busy(busy)
  );
  always #5 rclk = ~rclk;
  // FIFO model: pops on rinc sampled at the edge, then absorbs words queued by the stimulus
  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      fifo.delete();
      bus.rempty = 1'b1;
      bus.rdata = '0;
    end else begin
      p = bus.rinc;
      n_cmp++;
      assert (!(p && bus.rempty)) else begin
        n_bad++;
        $error("FAIL rinc_underflow: rinc=%0b rempty=%0b required no pop when empty", p, bus.rempty);
      end
      if (bus.m_valid && bus.m_ready) rcv.push_back({bus.m_data, bus.m_keep, bus.m_last});
      #1;
      if (p && fifo.size() != 0) void'(fifo.pop_front());
      while (inq.size() != 0) fifo.push_back(inq.pop_front());
      bus.rempty = fifo.size() == 0;
      bus.rdata = fifo.size() != 0 ? fifo[0] : '0;
    end
  end
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_beat(string tag, logic [15:0] d, logic [1:0] k, logic l);
    beat_t b;
    if (rcv.size() != 0) b = rcv.pop_front();
    else b = '1;
    chk({tag, "_data"}, b.d, d);
    chk({tag, "_keep"}, b.k, k);
    chk({tag, "_last"}, b.l, l);
  endtask
  task automatic wait_beats(string tag, int n, int budget);
    for (int i = 0; i < budget && rcv.size() < n; i++) @(negedge rclk);
    chk({tag, "_beats_seen"}, rcv.size() >= n, 1);
  endtask
  task automatic push4();
    inq.push_back(8'h11);
    inq.push_back(8'h22);
    inq.push_back(8'h33);
    inq.push_back(8'h44);
  endtask
  initial begin
    bus.m_ready = 1'b1;
    repeat (3) @(negedge rclk);
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_data", bus.m_data, 0);
    chk("rst_keep", bus.m_keep, 0);
    chk("rst_last", bus.m_last, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_rinc", bus.rinc, 0);
    chk("rst_busy", busy, 0);
    rrst_n = 1'b1;
    // 1: two full beats
    push4();
    wait_beats("t1", 2, 30);
    chk_beat("t1_b0", 16'h2211, 2'b11, 1'b0);
    chk_beat("t1_b1", 16'h4433, 2'b11, 1'b0);
    repeat (2) @(negedge rclk);
    chk("t1_beat_cnt", beat_cnt, 2);
    chk("t1_busy", busy, 0);
    // 2: flush of a single popped word
    inq.push_back(8'hA5);
    for (int i = 0; i < 20 && !busy; i++) @(negedge rclk);
    chk("t2_popped", busy, 1);
    flush = 1'b1;
    @(negedge rclk);
    flush = 1'b0;
    wait_beats("t2", 1, 20);
    chk_beat("t2_b0", 16'h00A5, 2'b01, 1'b1);
    repeat (2) @(negedge rclk);
    chk("t2_busy", busy, 0);
    chk("t2_beat_cnt", beat_cnt, 3);
    // 3: backpressure holds beat, fills acc, leaves the rest in the FIFO
    bus.m_ready = 1'b0;
    push4();
    inq.push_back(8'h55);
    inq.push_back(8'h66);
    repeat (10) @(negedge rclk);
    chk("t3_valid", bus.m_valid, 1);
    chk("t3_data", bus.m_data, 16'h2211);
    chk("t3_keep", bus.m_keep, 2'b11);
    chk("t3_rinc", bus.rinc, 0);
    chk("t3_fifo_left", fifo.size(), 2);
    chk("t3_busy", busy, 1);
    repeat (3) @(negedge rclk);
    chk("t3_data_stable", bus.m_data, 16'h2211);
    bus.m_ready = 1'b1;
    wait_beats("t3", 3, 30);
    chk_beat("t3_b0", 16'h2211, 2'b11, 1'b0);
    chk_beat("t3_b1", 16'h4433, 2'b11, 1'b0);
    chk_beat("t3_b2", 16'h6655, 2'b11, 1'b0);
    repeat (2) @(negedge rclk);
    chk("t3_beat_cnt", beat_cnt, 6);
    chk("t3_fifo_empty", fifo.size(), 0);
    // 4: flush with nothing accumulated is ignored
    flush = 1'b1;
    @(negedge rclk);
    flush = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_valid", bus.m_valid, 0);
    repeat (3) @(negedge rclk);
    chk("t4_no_beat", rcv.size(), 0);
    chk("t4_valid_late", bus.m_valid, 0);
    chk("t4_beat_cnt", beat_cnt, 6);
    // 5: 40 words with a stuttering m_ready
    @(negedge rclk);
    rrst_n = 1'b0;
    repeat (2) @(negedge rclk);
    rcv.delete();
    rrst_n = 1'b1;
    chk("t5_beat_cnt_rst", beat_cnt, 0);
    for (int c = 0; c < 400; c++) begin
      if (c < 40) inq.push_back(8'(c * 7 + 3));
      bus.m_ready = (c % 3) != 2;
      @(negedge rclk);
      if (c >= 40 && rcv.size() >= 20) break;
    end
    bus.m_ready = 1'b1;
    repeat (3) @(negedge rclk);
    chk("t5_nbeats", rcv.size(), 20);
    for (int k = 0; k < 20; k++)
      chk_beat($sformatf("t5_b%0d", k), {8'((2 * k + 1) * 7 + 3), 8'(2 * k * 7 + 3)}, 2'b11, 1'b0);
    chk("t5_beat_cnt", beat_cnt, 20);
    // 6: reset while a beat is held
    bus.m_ready = 1'b0;
    inq.push_back(8'h77);
    inq.push_back(8'h88);
    repeat (6) @(negedge rclk);
    chk("t6_valid_before", bus.m_valid, 1);
    #2 rrst_n = 1'b0;
    #1;
    chk("t6_valid_rst", bus.m_valid, 0);
    chk("t6_beat_cnt_rst", beat_cnt, 0);
    chk("t6_data_rst", bus.m_data, 0);
    chk("t6_busy_rst", busy, 0);
    @(negedge rclk);
    rcv.delete();
    rrst_n = 1'b1;
    bus.m_ready = 1'b1;
    push4();
    wait_beats("t6", 2, 30);
    chk_beat("t6_b0", 16'h2211, 2'b11, 1'b0);
    chk_beat("t6_b1", 16'h4433, 2'b11, 1'b0);
    repeat (2) @(negedge rclk);
    chk("t6_beat_cnt", beat_cnt, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule
